// File: rtl/fetch_decode.sv
// Fetch/decode stage: PC, imem request handshake, one-entry skid
// and registered MIPS-style field decode for the register file.
module fetch_decode #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        dec_valid,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  dst_addr,
  output logic        rf_we,
  output logic [31:0] imm_ext
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  dst;
    logic        we;
    logic [31:0] imm;
  } dec_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic        req_q;
  dec_t        dec_q, dec_new;
  logic        load, bubble, accept;
  logic [31:0] load_word;
  logic [31:0] pc_inc;

  function automatic dec_t decode(
    input logic [31:0] ins,
    input logic [31:0] pc
  );
    dec_t       d;
    logic [5:0] op;
    op      = ins[31:26];
    d       = '0;
    d.valid = 1'b1;
    d.pc    = pc;
    d.instr = ins;
    d.imm   = {{16{ins[15]}}, ins[15:0]};
    unique case (1'b1)
      op == 6'h00: begin
        d.dst = ins[15:11];
        d.we  = ins[5:0] != 6'h08;
      end
      op inside {6'h08, 6'h09, 6'h0A, 6'h0C,
                 6'h0D, 6'h0F, 6'h23}: begin
        d.dst = ins[20:16];
        d.we  = 1'b1;
      end
      op == 6'h03: begin
        d.dst = 5'd31;
        d.we  = 1'b1;
      end
      default: ;
    endcase
    unique case (1'b1)
      op inside {6'h0C, 6'h0D}:
        d.imm = {16'h0, ins[15:0]};
      op == 6'h0F:
        d.imm = {ins[15:0], 16'h0};
      op inside {6'h02, 6'h03}:
        d.imm = {6'b0, ins[25:0]};
      default: ;
    endcase
    // r0 is hardwired, so never request a write to it
    if (d.dst == 5'd0) d.we = 1'b0;
    return d;
  endfunction

  assign pc_inc  = pc_q + 32'd4;
  assign accept  = req_q & imem_valid;
  assign dec_new = decode(load_word, pc_q);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    skid_d    = skid_q;
    load      = 1'b0;
    bubble    = 1'b0;
    load_word = imem_rdata;
    if (branch_taken) begin
      pc_d   = branch_target & 32'hFFFF_FFFC;
      skid_d = '0;
      bubble = 1'b1;
      unique case (state_q)
        // no request outstanding yet: nothing to drain
        FETCH:
          state_d = (accept || !req_q) ?
                    FETCH : DISCARD;
        HOLD:
          state_d = FETCH;
        DISCARD:
          state_d = imem_valid ?
                    FETCH : DISCARD;
        default:
          state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (accept && !stall) begin
            load = 1'b1;
            pc_d = pc_inc;
          end else if (accept) begin
            skid_d  = imem_rdata;
            state_d = HOLD;
          end else if (!stall) begin
            bubble = 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            load      = 1'b1;
            load_word = skid_q;
            pc_d      = pc_inc;
            state_d   = FETCH;
          end
        end
        DISCARD: begin
          if (imem_valid) state_d = FETCH;
        end
        default:
          state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc_q    <= PC_RESET;
      skid_q  <= '0;
      req_q   <= 1'b0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      req_q   <= state_d == FETCH;
      if (load) begin
        dec_q <= dec_new;
      end else if (bubble) begin
        dec_q.valid <= 1'b0;
        dec_q.we    <= 1'b0;
      end
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign dec_valid = dec_q.valid;
  assign dec_pc    = dec_q.pc;
  assign dec_instr = dec_q.instr;
  assign opcode    = dec_q.instr[31:26];
  assign funct     = dec_q.instr[5:0];
  assign rs_addr   = dec_q.instr[25:21];
  assign rt_addr   = dec_q.instr[20:16];
  assign dst_addr  = dec_q.dst;
  assign rf_we     = dec_q.we;
  assign imm_ext   = dec_q.imm;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: decode fields, stall skid,
// branch discard, PC wrap and mid-request reset.
module tb_fetch_decode;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  dst_addr;
  logic        rf_we;
  logic [31:0] imm_ext;

  int checks = 0;
  int errors = 0;

  fetch_decode dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .dec_valid    (dec_valid),
    .dec_pc       (dec_pc),
    .dec_instr    (dec_instr),
    .opcode       (opcode),
    .funct        (funct),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .dst_addr     (dst_addr),
    .rf_we        (rf_we),
    .imm_ext      (imm_ext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input logic [31:0] w);
    imem_valid = 1'b1;
    imem_rdata = w;
    step();
    imem_valid = 1'b0;
    imem_rdata = '0;
  endtask

  initial begin
    reset_n       = 1'b0;
    imem_valid    = 1'b0;
    imem_rdata    = '0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_dv", dec_valid, 0);
    check("rst_we", rf_we, 0);
    check("rst_imm", imm_ext, 0);
    #21 reset_n = 1'b1;
    step();
    check("req_rise", imem_req, 1);
    check("req_addr0", imem_addr, 0);

    // 1: add $8,$9,$10
    resp(32'h012A4020);
    check("add_dv", dec_valid, 1);
    check("add_pc", dec_pc, 0);
    check("add_rs", rs_addr, 9);
    check("add_rt", rt_addr, 10);
    check("add_dst", dst_addr, 8);
    check("add_we", rf_we, 1);
    check("add_next", imem_addr, 4);
    check("add_op", opcode, 0);
    check("add_fn", funct, 6'h20);

    // 2: immediates
    resp(32'h2005FFFF);
    check("addi_pc", dec_pc, 4);
    check("addi_dst", dst_addr, 5);
    check("addi_we", rf_we, 1);
    check("addi_imm", imm_ext, 32'hFFFFFFFF);
    resp(32'h3405FFFF);
    check("ori_imm", imm_ext, 32'h0000FFFF);
    check("ori_we", rf_we, 1);
    resp(32'h3C05FFFF);
    check("lui_imm", imm_ext, 32'hFFFF0000);
    step();
    check("bub_dv", dec_valid, 0);
    check("bub_we", rf_we, 0);

    // 3: stall with response -> skid
    resp(32'h012A4020);
    check("pre_pc", dec_pc, 16);
    stall = 1'b1;
    resp(32'h20060007);
    check("stl_req", imem_req, 0);
    check("stl_pc", dec_pc, 16);
    check("stl_dst", dst_addr, 8);
    check("stl_addr", imem_addr, 20);
    step();
    step();
    check("stl_hold_pc", dec_pc, 16);
    check("stl_hold_req", imem_req, 0);
    stall = 1'b0;
    step();
    check("skid_dv", dec_valid, 1);
    check("skid_pc", dec_pc, 20);
    check("skid_dst", dst_addr, 6);
    check("skid_imm", imm_ext, 7);
    check("skid_addr", imem_addr, 24);
    check("skid_req", imem_req, 1);
    step();
    check("nodup_dv", dec_valid, 0);

    // 4: branch while request outstanding
    branch_taken  = 1'b1;
    branch_target = 32'h00000103;
    step();
    branch_taken  = 1'b0;
    check("br_req", imem_req, 0);
    check("br_dv", dec_valid, 0);
    check("br_addr", imem_addr, 32'h100);
    resp(32'h012A4020);
    check("late_dv", dec_valid, 0);
    check("late_req", imem_req, 1);
    check("late_addr", imem_addr, 32'h100);
    resp(32'h0C000010);
    check("jal_pc", dec_pc, 32'h100);
    check("jal_dst", dst_addr, 31);
    check("jal_we", rf_we, 1);
    check("jal_imm", imm_ext, 32'h10);

    // 5: non-writing instructions
    resp(32'hAD280004);
    check("sw_we", rf_we, 0);
    check("sw_dst", dst_addr, 0);
    resp(32'h1109FFFE);
    check("beq_we", rf_we, 0);
    check("beq_imm", imm_ext, 32'hFFFFFFFE);
    resp(32'h08000040);
    check("j_we", rf_we, 0);
    check("j_imm", imm_ext, 32'h40);
    resp(32'hFC000000);
    check("unk_dv", dec_valid, 1);
    check("unk_we", rf_we, 0);
    check("unk_dst", dst_addr, 0);
    resp(32'h012A0020);
    check("rd0_we", rf_we, 0);
    resp(32'h01200008);
    check("jr_we", rf_we, 0);

    // 6: branch with same-cycle response, then PC wrap
    imem_valid    = 1'b1;
    imem_rdata    = 32'h012A4020;
    branch_taken  = 1'b1;
    branch_target = 32'hFFFFFFFF;
    step();
    imem_valid   = 1'b0;
    branch_taken = 1'b0;
    check("brv_addr", imem_addr, 32'hFFFFFFFC);
    check("brv_req", imem_req, 1);
    check("brv_dv", dec_valid, 0);
    resp(32'h012A4020);
    check("wrap_pc", dec_pc, 32'hFFFFFFFC);
    check("wrap_addr", imem_addr, 0);
    resp(32'h2005FFFF);
    check("post_wrap_pc", dec_pc, 0);
    check("post_wrap_addr", imem_addr, 4);

    // mid-request reset
    reset_n = 1'b0;
    #2;
    check("mrst_dv", dec_valid, 0);
    check("mrst_req", imem_req, 0);
    check("mrst_addr", imem_addr, 0);
    check("mrst_dst", dst_addr, 0);
    check("mrst_imm", imm_ext, 0);
    #2;
    reset_n    = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'h012A4020;
    step();
    imem_valid = 1'b0;
    check("ign_dv", dec_valid, 0);
    check("ign_req", imem_req, 1);
    check("ign_addr", imem_addr, 0);
    resp(32'h3405FFFF);
    check("rst2_dv", dec_valid, 1);
    check("rst2_pc", dec_pc, 0);
    check("rst2_imm", imm_ext, 32'h0000FFFF);
    check("rst2_addr", imem_addr, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
